wb_regfile: RTL

Write-back stage and general-purpose register file of the 5-stage CPU. Consumes the MEM/WB pipeline register outputs and selects the write-back data (memory read data or ALU result). It commits that data to a 32 x 32-bit register file and serves the two decode-stage read ports, with same-cycle write-through bypass. It also keeps a saturating count of retired (non-bubble) instructions for debug and performance checks.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/regfile_core.sv | 46 ++++
 rtl/wb_regfile.sv | 116 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : cpu_pkg                                                      |
// | Description: Shared constants and helpers for the 5-stage CPU datapath.  |
// |              Used by MEM/WB, write-back/register file and forwarding.    |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
package cpu_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  // Architectural zero register and the all-zero bubble encoding
  localparam logic [4:0]  ZERO_REG  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'b0;

  // Saturating +1: sticks at all-ones instead of wrapping to zero
  function automatic logic [31:0] sat_inc32(input logic [31:0] i_val);
    return (i_val == 32'hFFFF_FFFF) ? i_val : i_val + 32'd1;
  endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/regfile_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : regfile_core                                                |
// | Description: Raw register storage array. Asynchronous clear, one         |
// |              synchronous write port, two combinational read ports.       |
// |              No zero-register or bypass handling at this level.          |
// | Ports      : clk, rst        - clock, async active-high clear            |
// |              i_we            - write strobe                              |
// |              i_waddr/i_wdata - write index / data                        |
// |              i_raddr_a/b     - read indices                              |
// |              o_rdata_a/b     - stored contents at the read indices       |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module regfile_core #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule : regfile_core
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : wb_regfile                                                  |
// | Description: Write-back stage plus general-purpose register file.        |
// |              Selects write-back data, commits it, serves two decode read |
// |              ports with same-cycle write-through bypass, and counts      |
// |              retired (non-bubble) instructions with saturation.          |
// | Ports      : clk, rst         - clock, async active-high reset           |
// |              wb_*  (inputs)   - MEM/WB pipeline register outputs         |
// |              rs_addr/rt_addr  - decode read indices                      |
// |              rs_data/rt_data  - read data (combinational, bypassed)      |
// |              wb_write_data    - selected write-back value                |
// |              wb_write_en      - effective write strobe (never for r0)    |
// |              retired_count    - saturating retired-instruction count     |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module wb_regfile #(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       wb_instruction,
  input  logic              wb_mem_to_reg,
  input  logic              wb_reg_write,
  input  logic [ADDR_W-1:0] wb_write_reg,
  input  logic [DATA_W-1:0] wb_read_data,
  input  logic [DATA_W-1:0] wb_alu_res,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_write_data,
  output logic              wb_write_en,
  output logic [31:0]       retired_count
);

  import cpu_pkg::*;

  logic [ADDR_W-1:0] w_zero_idx;
  logic [DATA_W-1:0] w_write_data;
  logic              w_write_en;
  logic [DATA_W-1:0] w_raw_rs;
  logic [DATA_W-1:0] w_raw_rt;
  logic              w_rs_is_zero;
  logic              w_rt_is_zero;
  logic              w_rs_bypass;
  logic              w_rt_bypass;
  logic [31:0]       r_retired_count;

  assign w_zero_idx = ADDR_W'(ZERO_REG);

  // Mux is live every cycle; the forwarding unit consumes it even when
  // no register write is taking place.
  assign w_write_data = wb_mem_to_reg ? wb_read_data : wb_alu_res;

  // Gating the strobe for r0 keeps the stored r0 at zero forever.
  assign w_write_en = wb_reg_write && (wb_write_reg != w_zero_idx);

  regfile_core #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_write_en),
    .i_waddr   (wb_write_reg),
    .i_wdata   (w_write_data),
    .i_raddr_a (rs_addr),
    .i_raddr_b (rt_addr),
    .o_rdata_a (w_raw_rs),
    .o_rdata_b (w_raw_rt)
  );

  // Write-through bypass resolves the WB->ID hazard without a stall.
  // w_write_en is already false for r0, so r0 can never be bypassed.
  assign w_rs_is_zero = (rs_addr == w_zero_idx);
  assign w_rt_is_zero = (rt_addr == w_zero_idx);
  assign w_rs_bypass  = w_write_en && (wb_write_reg == rs_addr);
  assign w_rt_bypass  = w_write_en && (wb_write_reg == rt_addr);

  always_comb begin
    rs_data = w_raw_rs;
    if (w_rs_is_zero) begin
      rs_data = '0;
    end else if (w_rs_bypass) begin
      rs_data = w_write_data;
    end
  end

  always_comb begin
    rt_data = w_raw_rt;
    if (w_rt_is_zero) begin
      rt_data = '0;
    end else if (w_rt_bypass) begin
      rt_data = w_write_data;
    end
  end

  // Stores and branches retire too, so only the bubble encoding is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retired_count <= '0;
    end else if (wb_instruction != NOP_INSTR) begin
      r_retired_count <= sat_inc32(r_retired_count);
    end
  end

  assign wb_write_data = w_write_data;
  assign wb_write_en   = w_write_en;
  assign retired_count = r_retired_count;

endmodule : wb_regfile
`default_nettype wire
